// File: rtl/audio_mix_sched.sv
// Four-channel audio mixer: snapshots samples once per frame, runs one shared
// multiplier across the channels and publishes left/right sums for a sigma-delta stage.
module audio_mix_sched #(
  parameter int ID = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  aud0,
  input  logic [7:0]  aud1,
  input  logic [7:0]  aud2,
  input  logic [7:0]  aud3,
  input  logic [6:0]  vol0,
  input  logic [6:0]  vol1,
  input  logic [6:0]  vol2,
  input  logic [6:0]  vol3,
  input  logic [3:0]  chen,
  output logic        smp_ack,
  output logic [14:0] ldatasum,
  output logic [14:0] rdatasum,
  output logic        out_stb
);

  logic [ID-1:0]      cnt_q, cnt_d;
  logic [7:0]         cnt8;
  logic [7:0]         aud_q [4];
  logic [7:0]         aud_d [4];
  logic [6:0]         vol_q [4];
  logic [6:0]         vol_d [4];
  logic [3:0]         chen_q, chen_d;
  logic signed [13:0] prod_q, prod_d;
  logic signed [14:0] lacc_q, lacc_d, racc_q, racc_d;
  logic [14:0]        ldata_q, ldata_d, rdata_q, rdata_d;
  logic               smp_ack_q, smp_ack_d, out_stb_q, out_stb_d;

  logic [1:0]         sel;
  logic [6:0]         vol_sel, vol_c;
  logic signed [13:0] mul_a, mul_b, mul_p;
  logic signed [14:0] prod_ext;

  // Slot 1..4 maps to channel 0..3; the 2-bit wrap makes slot 4 land on channel 3.
  always_comb begin
    cnt8     = {{(8-ID){1'b0}}, cnt_q};
    sel      = cnt8[1:0] - 2'd1;
    vol_sel  = vol_q[sel];
    vol_c    = (vol_sel > 7'd64) ? 7'd64 : vol_sel;
    mul_a    = {{6{aud_q[sel][7]}}, aud_q[sel]};
    mul_b    = {7'd0, vol_c};
    mul_p    = mul_a * mul_b;
    prod_ext = {prod_q[13], prod_q};
  end

  always_comb begin
    cnt_d     = cnt_q + ID'(1);
    aud_d     = aud_q;
    vol_d     = vol_q;
    chen_d    = chen_q;
    prod_d    = prod_q;
    lacc_d    = lacc_q;
    racc_d    = racc_q;
    ldata_d   = ldata_q;
    rdata_d   = rdata_q;
    smp_ack_d = 1'b0;
    out_stb_d = 1'b0;

    if (cnt8 == 8'd0) begin
      aud_d[0]  = aud0;
      aud_d[1]  = aud1;
      aud_d[2]  = aud2;
      aud_d[3]  = aud3;
      vol_d[0]  = vol0;
      vol_d[1]  = vol1;
      vol_d[2]  = vol2;
      vol_d[3]  = vol3;
      chen_d    = chen;
      lacc_d    = '0;
      racc_d    = '0;
      smp_ack_d = 1'b1;
    end
    if (cnt8 >= 8'd1 && cnt8 <= 8'd4)
      prod_d = chen_q[sel] ? mul_p : '0;
    // Accumulation trails the multiply by one slot: ch0/ch3 go left, ch1/ch2 go right.
    if (cnt8 == 8'd2 || cnt8 == 8'd5)
      lacc_d = lacc_q + prod_ext;
    if (cnt8 == 8'd3 || cnt8 == 8'd4)
      racc_d = racc_q + prod_ext;
    if (cnt8 == 8'd6) begin
      ldata_d   = lacc_q;
      rdata_d   = racc_q;
      out_stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        aud_q[i] <= '0;
        vol_q[i] <= '0;
      end
      chen_q    <= '0;
      prod_q    <= '0;
      lacc_q    <= '0;
      racc_q    <= '0;
      ldata_q   <= '0;
      rdata_q   <= '0;
      smp_ack_q <= 1'b0;
      out_stb_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      aud_q     <= aud_d;
      vol_q     <= vol_d;
      chen_q    <= chen_d;
      prod_q    <= prod_d;
      lacc_q    <= lacc_d;
      racc_q    <= racc_d;
      ldata_q   <= ldata_d;
      rdata_q   <= rdata_d;
      smp_ack_q <= smp_ack_d;
      out_stb_q <= out_stb_d;
    end
  end

  assign smp_ack  = smp_ack_q;
  assign out_stb  = out_stb_q;
  assign ldatasum = ldata_q;
  assign rdatasum = rdata_q;

endmodule

// File: tb/tb_audio_mix_sched.sv
// Bench for audio_mix_sched (ID=4): directed frames with known sums plus random
// frames checked against a plain-arithmetic mixing model.
module tb_audio_mix_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  aud [4];
  logic [6:0]  vol [4];
  logic [3:0]  chen;
  logic        smp_ack, out_stb;
  logic [14:0] ldatasum, rdatasum;
  logic [3:0]  tcnt = 4'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Frame position as defined by the free-running counter rule (16-clock frame).
  always @(posedge clk) tcnt <= reset ? 4'd0 : tcnt + 4'd1;

  audio_mix_sched #(.ID(4)) dut (
    .clk(clk), .reset(reset),
    .aud0(aud[0]), .aud1(aud[1]), .aud2(aud[2]), .aud3(aud[3]),
    .vol0(vol[0]), .vol1(vol[1]), .vol2(vol[2]), .vol3(vol[3]),
    .chen(chen), .smp_ack(smp_ack), .ldatasum(ldatasum), .rdatasum(rdatasum),
    .out_stb(out_stb)
  );

  // Mixed sum of the channels currently on the inputs: left = ch0+ch3, right = ch1+ch2.
  function automatic logic [14:0] ref_mix(input bit left);
    int s, a, v;
    s = 0;
    for (int c = 0; c < 4; c++) begin
      if (chen[c] && (((c == 0) || (c == 3)) == left)) begin
        a = $signed(aud[c]);
        v = (vol[c] > 7'd64) ? 64 : int'(vol[c]);
        s += a * v;
      end
    end
    return 15'(s);
  endfunction

  task automatic wait_t(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tcnt != 4'(k) && n < 40);
    if (tcnt != 4'(k)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_t: frame position %0d never reached, got %0d", k, tcnt);
    end
  endtask

  task automatic set_rand();
    for (int c = 0; c < 4; c++) begin
      aud[c] = 8'($urandom);
      vol[c] = 7'($urandom_range(0, 127));
    end
    chen = 4'($urandom);
  endtask

  // Checks the output window around the strobe of the current frame.
  task automatic check_out(input string nm, input logic [14:0] el, input logic [14:0] er);
    wait_t(6);
    n_cmp++; if (out_stb !== 1'b0) begin n_bad++; $display("FAIL %s out_stb@6 got %b want 0", nm, out_stb); end
    wait_t(7);
    n_cmp++; if (out_stb !== 1'b1) begin n_bad++; $display("FAIL %s out_stb@7 got %b want 1", nm, out_stb); end
    n_cmp++; if (ldatasum !== el) begin n_bad++; $display("FAIL %s ldatasum got %h want %h", nm, ldatasum, el); end
    n_cmp++; if (rdatasum !== er) begin n_bad++; $display("FAIL %s rdatasum got %h want %h", nm, rdatasum, er); end
    wait_t(12);
    n_cmp++; if (out_stb !== 1'b0 || ldatasum !== el || rdatasum !== er) begin
      n_bad++; $display("FAIL %s idle hold got stb=%b l=%h r=%h want 0/%h/%h", nm, out_stb, ldatasum, rdatasum, el, er);
    end
    $display("frame %s: l=%h r=%h (expected %h %h)", nm, ldatasum, rdatasum, el, er);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3, input logic [6:0] v0,
                           input logic [6:0] v1, input logic [6:0] v2, input logic [6:0] v3,
                           input logic [3:0] en, input logic [14:0] el, input logic [14:0] er);
    wait_t(15);
    set_rand();
    aud[0] = a0; aud[1] = a1; aud[2] = a2; aud[3] = a3;
    vol[0] = v0; vol[1] = v1; vol[2] = v2; vol[3] = v3;
    chen = en;
    wait_t(1);
    n_cmp++; if (smp_ack !== 1'b1) begin n_bad++; $display("FAIL %s smp_ack@1 got %b want 1", nm, smp_ack); end
    wait_t(2);
    n_cmp++; if (smp_ack !== 1'b0) begin n_bad++; $display("FAIL %s smp_ack@2 got %b want 0", nm, smp_ack); end
    check_out(nm, el, er);
  endtask

  task automatic test_reset();
    int first_stb, first_ack;
    set_rand();
    aud[0] = 8'd127; vol[0] = 7'd64; chen = 4'b0001;
    repeat (3) @(negedge clk);
    n_cmp++; if (ldatasum !== 15'd0 || rdatasum !== 15'd0) begin
      n_bad++; $display("FAIL reset sums got %h %h want 0 0", ldatasum, rdatasum);
    end
    n_cmp++; if (smp_ack !== 1'b0 || out_stb !== 1'b0) begin
      n_bad++; $display("FAIL reset strobes got ack=%b stb=%b want 0 0", smp_ack, out_stb);
    end
    reset = 1'b0;
    first_stb = 0; first_ack = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_stb && first_stb == 0) first_stb = i;
      if (smp_ack && first_ack == 0) first_ack = i;
      if (i == 6) begin
        n_cmp++; if (ldatasum !== 15'd0) begin n_bad++; $display("FAIL reset early_output got %h want 0", ldatasum); end
      end
      if (i == 7) begin
        n_cmp++; if (ldatasum !== 15'h1FC0) begin n_bad++; $display("FAIL reset first_frame got %h want 1fc0", ldatasum); end
      end
    end
    n_cmp++; if (first_ack !== 1) begin n_bad++; $display("FAIL reset first_smp_ack got %0d want 1", first_ack); end
    n_cmp++; if (first_stb !== 7) begin n_bad++; $display("FAIL reset first_out_stb got %0d want 7", first_stb); end
    $display("reset release: smp_ack at %0d, out_stb at %0d", first_ack, first_stb);
  endtask

  task automatic test_single_ch0();
    run_frame("ch0_full", 8'd127, 8'h55, 8'hAA, 8'h33, 7'd64, 7'd64, 7'd64, 7'd64, 4'b0001, 15'h1FC0, 15'd0);
  endtask

  task automatic test_all_neg();
    run_frame("all_neg", 8'h80, 8'h80, 8'h80, 8'h80, 7'd64, 7'd64, 7'd64, 7'd64, 4'b1111, 15'h4000, 15'h4000);
  endtask

  task automatic test_clamp();
    run_frame("clamp", 8'h12, 8'hFF, 8'h34, 8'h56, 7'd64, 7'd100, 7'd64, 7'd64, 4'b0010, 15'd0, 15'h7FC0);
  endtask

  task automatic test_input_change();
    wait_t(15);
    set_rand();
    aud[0] = 8'd127; vol[0] = 7'd64; chen = 4'b0001;
    wait_t(3);
    aud[0] = 8'd0; aud[1] = 8'hFF; vol[1] = 7'd100; chen = 4'b0010;
    check_out("change_cur", 15'h1FC0, 15'd0);
    check_out("change_next", 15'd0, 15'h7FC0);
  endtask

  task automatic test_reset_mid();
    int first_stb;
    bit early_bad;
    wait_t(15);
    for (int c = 0; c < 4; c++) begin aud[c] = 8'h80; vol[c] = 7'd64; end
    chen = 4'b1111;
    wait_t(4);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (ldatasum !== 15'd0 || rdatasum !== 15'd0 || out_stb !== 1'b0 || smp_ack !== 1'b0) begin
      n_bad++; $display("FAIL midreset held got l=%h r=%h stb=%b ack=%b want all 0", ldatasum, rdatasum, out_stb, smp_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    first_stb = 0; early_bad = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_stb && first_stb == 0) first_stb = i;
      if (i < 7 && (out_stb !== 1'b0 || ldatasum !== 15'd0 || rdatasum !== 15'd0)) early_bad = 1'b1;
      if (i == 7) begin
        n_cmp++; if (ldatasum !== 15'h4000 || rdatasum !== 15'h4000) begin
          n_bad++; $display("FAIL midreset next_frame got %h %h want 4000 4000", ldatasum, rdatasum);
        end
      end
    end
    n_cmp++; if (early_bad) begin n_bad++; $display("FAIL midreset partial_output got early activity want none"); end
    n_cmp++; if (first_stb !== 7) begin n_bad++; $display("FAIL midreset first_out_stb got %0d want 7", first_stb); end
    $display("mid-frame reset: first out_stb at %0d", first_stb);
  endtask

  task automatic test_free_run();
    int ack_t[$];
    int stb_t[$];
    wait_t(15);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (smp_ack) ack_t.push_back(i);
      if (out_stb) stb_t.push_back(i);
    end
    n_cmp++; if (ack_t.size() !== 4) begin n_bad++; $display("FAIL freerun smp_ack_count got %0d want 4", ack_t.size()); end
    n_cmp++; if (stb_t.size() !== 4) begin n_bad++; $display("FAIL freerun out_stb_count got %0d want 4", stb_t.size()); end
    if (ack_t.size() == 4 && stb_t.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (stb_t[k] - ack_t[k] !== 6) begin
          n_bad++; $display("FAIL freerun ack_to_stb[%0d] got %0d want 6", k, stb_t[k] - ack_t[k]);
        end
        if (k > 0) begin
          n_cmp++; if (ack_t[k] - ack_t[k-1] !== 16 || stb_t[k] - stb_t[k-1] !== 16) begin
            n_bad++; $display("FAIL freerun period[%0d] got %0d/%0d want 16", k, ack_t[k] - ack_t[k-1], stb_t[k] - stb_t[k-1]);
          end
        end
      end
    end
    $display("free run: %0d smp_ack, %0d out_stb pulses in 64 clocks", ack_t.size(), stb_t.size());
  endtask

  task automatic test_random();
    logic [14:0] el, er;
    for (int f = 0; f < 12; f++) begin
      wait_t(15);
      set_rand();
      el = ref_mix(1'b1);
      er = ref_mix(1'b0);
      wait_t(1);
      n_cmp++; if (smp_ack !== 1'b1) begin n_bad++; $display("FAIL rand%0d smp_ack got %b want 1", f, smp_ack); end
      if ($urandom_range(0, 1) == 1) begin
        wait_t(3);
        set_rand();
      end
      check_out($sformatf("rand%0d", f), el, er);
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin aud[c] = '0; vol[c] = '0; end
    chen = '0;
    test_reset();
    test_single_ch0();
    test_all_neg();
    test_clamp();
    test_input_change();
    test_reset_mid();
    test_free_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
